// File: rtl/fifo_drain_serializer.sv
`default_nettype none
// ============================================================================
// fifo_drain_serializer : drains IN_WIDTH-bit FIFO words and emits them as
//                         OUT_WIDTH-bit valid/ready beats, LSB chunk first.
// Revision: 1.0
// ============================================================================
module fifo_drain_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_en,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_value,
    output logic                 fifo_dequeue_en,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int c_ratio = IN_WIDTH / OUT_WIDTH;
    localparam int c_cnt_w = $clog2(c_ratio + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_ratio - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [c_cnt_w-1:0]    beat_cnt_q, beat_cnt_d;
    logic                  w_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            shreg_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        busy      = out_valid;
        out_data  = shreg_q[OUT_WIDTH-1:0];
        out_last  = out_valid && (beat_cnt_q == c_last_cnt);
        w_accept  = out_valid && out_ready;
        // Gated by reset so a word is never popped while state is being held in reset.
        fifo_dequeue_en = reset && !flush_en && !fifo_empty &&
                          ((state_q == ST_EMPTY) || (w_accept && out_last));

        state_d    = state_q;
        shreg_d    = shreg_q;
        beat_cnt_d = beat_cnt_q;

        if (flush_en) begin
            state_d    = ST_EMPTY;
            beat_cnt_d = '0;
        end else if (fifo_dequeue_en) begin
            shreg_d    = fifo_value;
            beat_cnt_d = '0;
            state_d    = ST_SEND;
        end else if (w_accept) begin
            if (out_last) begin
                state_d = ST_EMPTY;
            end else begin
                shreg_d    = shreg_q >> OUT_WIDTH;
                beat_cnt_d = beat_cnt_q + c_cnt_one;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_serializer.sv
`default_nettype none
// Directed bench: 64->16 serializer plus a RATIO=1 instance, each fed by a queue-modelled FIFO.
module tb_fifo_drain_serializer;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush_en;
    logic        fifo_empty;
    logic [63:0] fifo_value;
    logic        fifo_dequeue_en;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    logic        flush1;
    logic        fifo_empty1;
    logic [63:0] fifo_value1;
    logic        deq1;
    logic        valid1;
    logic [63:0] data1;
    logic        last1;
    logic        ready1;
    logic        busy1;

    int          n_vec = 0;
    int          n_err = 0;
    int          deq1_cnt = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        d0, d1;

    always #5 clk = ~clk;

    fifo_drain_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .flush_en(flush_en), .fifo_empty(fifo_empty),
        .fifo_value(fifo_value), .fifo_dequeue_en(fifo_dequeue_en), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    fifo_drain_serializer #(.IN_WIDTH(64), .OUT_WIDTH(64)) u_dut1 (
        .clk(clk), .reset(reset), .flush_en(flush1), .fifo_empty(fifo_empty1),
        .fifo_value(fifo_value1), .fifo_dequeue_en(deq1), .out_valid(valid1),
        .out_data(data1), .out_last(last1), .out_ready(ready1), .busy(busy1)
    );

    task automatic refresh_fifos();
        fifo_empty  = (q0.size() == 0);
        fifo_value  = (q0.size() != 0) ? q0[0] : 64'h0;
        fifo_empty1 = (q1.size() == 0);
        fifo_value1 = (q1.size() != 0) ? q1[0] : 64'h0;
    endtask

    // FIFO model: dequeue request sampled late in the low phase, popped just after the edge.
    always begin
        @(negedge clk);
        #4;
        d0 = fifo_dequeue_en;
        d1 = deq1;
        @(posedge clk);
        #1;
        if (d0 && q0.size() != 0) q0.delete(0);
        if (d1 && q1.size() != 0) begin
            q1.delete(0);
            deq1_cnt++;
        end
        refresh_fifos();
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({out_valid, out_last, busy, fifo_dequeue_en} !== 4'b0000 || out_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: valid/last/busy/deq=%b data=%h, required 0000 data=0000",
                     {out_valid, out_last, busy, fifo_dequeue_en}, out_data);
        end
        n_vec++;
        if ({valid1, busy1, deq1} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ratio1: valid/busy/deq=%b, required 000", {valid1, busy1, deq1});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] exp_d[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        @(negedge clk);
        out_ready = 1'b1;
        q0.push_back(64'h4444_3333_2222_1111);
        refresh_fifos();
        #1;
        n_vec++;
        if (fifo_dequeue_en !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_load: deq=%b valid=%b, required deq=1 valid=0", fifo_dequeue_en, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3) || fifo_dequeue_en !== 1'b0) begin
                n_err++;
                $display("FAIL single_beat%0d: valid=%b data=%h last=%b deq=%b, required 1 %h %b 0",
                         i, out_valid, out_data, out_last, fifo_dequeue_en, exp_d[i], (i == 3));
            end
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d[8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                  16'h5555, 16'h6666, 16'h7777, 16'h8888};
        @(negedge clk);
        out_ready = 1'b1;
        q0.push_back(64'h4444_3333_2222_1111);
        q0.push_back(64'h8888_7777_6666_5555);
        refresh_fifos();
        #1;
        n_vec++;
        if (fifo_dequeue_en !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_load: deq=%b, required 1", fifo_dequeue_en);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3 || i == 7) ||
                fifo_dequeue_en !== (i == 3)) begin
                n_err++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h last=%b deq=%b, required 1 %h %b %b",
                         i, out_valid, out_data, out_last, fifo_dequeue_en, exp_d[i],
                         (i == 3 || i == 7), (i == 3));
            end
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic        rdy[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] exp_d[6] = '{16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h4444};
        int          acc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        q0.push_back(64'h4444_3333_2222_1111);
        refresh_fifos();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = rdy[i];
            #1;
            if (out_valid && out_ready) acc++;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 5)) begin
                n_err++;
                $display("FAIL bp_cycle%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         i, out_valid, out_data, out_last, exp_d[i], (i == 5));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (acc != 4 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accepts: accepts=%0d valid=%b, required 4 0", acc, out_valid);
        end
    endtask

    task automatic test_flush();
        logic [15:0] exp_d[4] = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        @(negedge clk);
        out_ready = 1'b1;
        q0.push_back(64'h4444_3333_2222_1111);
        q0.push_back(64'h8888_7777_6666_5555);
        refresh_fifos();
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
            n_err++;
            $display("FAIL flush_beat0: valid=%b data=%h, required 1 1111", out_valid, out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        flush_en  = 1'b1;
        #1;
        n_vec++;
        if (fifo_dequeue_en !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h2222) begin
            n_err++;
            $display("FAIL flush_cycle: deq=%b valid=%b data=%h, required 0 1 2222",
                     fifo_dequeue_en, out_valid, out_data);
        end
        @(negedge clk);
        flush_en  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_dequeue_en !== 1'b1) begin
            n_err++;
            $display("FAIL flush_after: valid=%b busy=%b deq=%b, required 0 0 1",
                     out_valid, busy, fifo_dequeue_en);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3)) begin
                n_err++;
                $display("FAIL flush_next%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         i, out_valid, out_data, out_last, exp_d[i], (i == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b1;
        q0.push_back(64'h4444_3333_2222_1111);
        refresh_fifos();
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
            n_err++;
            $display("FAIL areset_pre: valid=%b data=%h, required 1 1111", out_valid, out_data);
        end
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, fifo_dequeue_en, busy} !== 3'b000 || out_data !== 16'h0) begin
            n_err++;
            $display("FAIL areset_now: valid/deq/busy=%b data=%h, required 000 0000",
                     {out_valid, fifo_dequeue_en, busy}, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        q0.push_back(64'h8888_7777_6666_5555);
        refresh_fifos();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || fifo_dequeue_en !== 1'b1) begin
            n_err++;
            $display("FAIL areset_resume: valid=%b deq=%b, required 0 1", out_valid, fifo_dequeue_en);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h5555) begin
            n_err++;
            $display("FAIL areset_first: valid=%b data=%h, required 1 5555", out_valid, out_data);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ratio1();
        logic [63:0] w[3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0};
        @(negedge clk);
        deq1_cnt = 0;
        ready1   = 1'b1;
        for (int i = 0; i < 3; i++) q1.push_back(w[i]);
        refresh_fifos();
        #1;
        n_vec++;
        if (deq1 !== 1'b1 || valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL r1_load: deq=%b valid=%b, required 1 0", deq1, valid1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (valid1 !== 1'b1 || data1 !== w[i] || last1 !== 1'b1 || busy1 !== 1'b1 || deq1 !== (i < 2)) begin
                n_err++;
                $display("FAIL r1_beat%0d: valid=%b data=%h last=%b busy=%b deq=%b, required 1 %h 1 1 %b",
                         i, valid1, data1, last1, busy1, deq1, w[i], (i < 2));
            end
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0 || deq1_cnt != 3) begin
            n_err++;
            $display("FAIL r1_end: busy=%b valid=%b dequeues=%0d, required 0 0 3", busy1, valid1, deq1_cnt);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush_en  = 1'b0;
        out_ready = 1'b0;
        flush1    = 1'b0;
        ready1    = 1'b0;
        refresh_fifos();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_ratio1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
